// File: rtl/adpll_pkg.sv
// rtl/adpll_pkg.sv - shared ADPLL types and default loop constants
package adpll_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    UPDATE  = 2'd2
  } meter_state_t;

  localparam int DEF_CNT_W     = 8;
  localparam int DEF_CTRL_W    = 12;
  localparam int DEF_CTRL_INIT = 2048;
  localparam int DEF_KP_SHIFT  = 2;
  localparam int DEF_KI_SHIFT  = 5;

endpackage

// File: rtl/updn_pulse_meter.sv
// rtl/updn_pulse_meter.sv - measures UP/DN pulse width as a signed error
module updn_pulse_meter
  import adpll_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              up,
  input  logic              dn,
  output logic signed [CNT_W:0] err,
  output logic              err_valid
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  meter_state_t     state, state_n;
  logic [CNT_W-1:0] count, count_n;
  logic             dir, dir_n;
  logic             latched_high, other_high;
  logic signed [CNT_W:0] mag;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
      dir   <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      dir   <= dir_n;
    end
  end

  assign latched_high = dir ? up : dn;
  assign other_high   = dir ? dn : up;

  always_comb begin
    state_n   = state;
    count_n   = count;
    dir_n     = dir;
    err_valid = 1'b0;
    case (state)
      IDLE: begin
        // Both high is the PFD reset overlap; only a lone input starts a pulse.
        if (up ^ dn) begin
          dir_n   = up;
          count_n = {{(CNT_W-1){1'b0}}, 1'b1};
          state_n = MEASURE;
        end
      end
      MEASURE: begin
        if (latched_high && !other_high) begin
          if (count != CNT_MAX) count_n = count + 1'b1;
        end else begin
          state_n = UPDATE;
        end
      end
      UPDATE: begin
        err_valid = 1'b1;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign mag = signed'({1'b0, count});
  assign err = dir ? mag : -mag;

endmodule

// File: rtl/loop_filter.sv
// rtl/loop_filter.sv - PI loop filter producing the DCO control word
module loop_filter
  import adpll_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int CTRL_W    = DEF_CTRL_W,
  parameter int CTRL_INIT = DEF_CTRL_INIT,
  parameter int KP_SHIFT  = DEF_KP_SHIFT,
  parameter int KI_SHIFT  = DEF_KI_SHIFT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              UP,
  input  logic              DN,
  output logic [CTRL_W-1:0] ctrl,
  output logic              ctrl_valid,
  output logic              sat
);

  // Two guard bits keep integ + err and the proportional sum free of overflow.
  localparam int INTEG_W = CTRL_W + KI_SHIFT + 2;
  localparam logic signed [INTEG_W-1:0] INTEG_INIT = INTEG_W'(CTRL_INIT * (2 ** KI_SHIFT));
  localparam logic signed [INTEG_W-1:0] INTEG_MAX  = INTEG_W'((2 ** CTRL_W - 1) * (2 ** KI_SHIFT));
  localparam logic signed [INTEG_W-1:0] CTRL_MAX_S = INTEG_W'(2 ** CTRL_W - 1);

  logic signed [CNT_W:0]     err;
  logic                      err_valid;
  logic signed [INTEG_W-1:0] err_ext, integ, integ_sum, integ_n, ctrl_sum;
  logic                      integ_clamp, ctrl_clamp;
  logic [CTRL_W-1:0]         ctrl_n;

  updn_pulse_meter #(.CNT_W(CNT_W)) u_meter (
    .clk       (clk),
    .reset     (reset),
    .up        (UP),
    .dn        (DN),
    .err       (err),
    .err_valid (err_valid)
  );

  assign err_ext = signed'({{(INTEG_W-CNT_W-1){err[CNT_W]}}, err});

  always_comb begin
    integ_sum   = integ + err_ext;
    integ_n     = integ_sum;
    integ_clamp = 1'b0;
    if (integ_sum < 0) begin
      integ_n     = '0;
      integ_clamp = 1'b1;
    end else if (integ_sum > INTEG_MAX) begin
      integ_n     = INTEG_MAX;
      integ_clamp = 1'b1;
    end

    ctrl_sum   = (integ_n >>> KI_SHIFT) + (err_ext >>> KP_SHIFT);
    ctrl_n     = ctrl_sum[CTRL_W-1:0];
    ctrl_clamp = 1'b0;
    if (ctrl_sum < 0) begin
      ctrl_n     = '0;
      ctrl_clamp = 1'b1;
    end else if (ctrl_sum > CTRL_MAX_S) begin
      ctrl_n     = '1;
      ctrl_clamp = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      integ      <= INTEG_INIT;
      ctrl       <= CTRL_W'(CTRL_INIT);
      ctrl_valid <= 1'b0;
      sat        <= 1'b0;
    end else begin
      ctrl_valid <= err_valid;
      if (err_valid) begin
        integ <= integ_n;
        ctrl  <= ctrl_n;
        sat   <= integ_clamp | ctrl_clamp;
      end
    end
  end

endmodule

// File: tb/tb_loop_filter.sv
// tb/tb_loop_filter.sv - directed self-checking bench for loop_filter
module tb_loop_filter;

  logic        clk;
  logic        reset;
  logic        UP;
  logic        DN;
  logic [11:0] ctrl;
  logic        ctrl_valid;
  logic        sat;

  int tests;
  int fails;
  int nvalid;
  int first;

  loop_filter dut (
    .clk        (clk),
    .reset      (reset),
    .UP         (UP),
    .DN         (DN),
    .ctrl       (ctrl),
    .ctrl_valid (ctrl_valid),
    .sat        (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    if (obs != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0; UP = 1'b0; DN = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Watch five negedges after the pulse ends; ctrl_valid should appear on the third.
  task automatic watch_valid(output int nv, output int fv);
    nv = 0;
    fv = -1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (ctrl_valid) begin
        nv++;
        if (fv < 0) fv = i;
      end
    end
  endtask

  task automatic run_pulse(input logic up, input logic dn, input int n,
                           output int nv, output int fv);
    @(posedge clk); #1;
    UP = up; DN = dn;
    repeat (n) @(posedge clk);
    #1;
    UP = 1'b0; DN = 1'b0;
    watch_valid(nv, fv);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    UP    = 1'b0;
    DN    = 1'b0;

    do_reset();
    @(negedge clk);
    check("reset_ctrl", ctrl, 2048);
    check("reset_valid", ctrl_valid, 0);
    check("reset_sat", sat, 0);

    run_pulse(1'b1, 1'b0, 4, nvalid, first);
    check("up4_ctrl", ctrl, 2049);
    check("up4_nvalid", nvalid, 1);
    check("up4_latency", first, 3);
    check("up4_sat", sat, 0);

    run_pulse(1'b0, 1'b1, 8, nvalid, first);
    check("dn8_ctrl", ctrl, 2045);
    check("dn8_nvalid", nvalid, 1);

    run_pulse(1'b1, 1'b0, 1, nvalid, first);
    check("up1_ctrl", ctrl, 2047);
    check("up1_latency", first, 3);

    run_pulse(1'b0, 1'b1, 1, nvalid, first);
    check("dn1_floor_ctrl", ctrl, 2046);

    run_pulse(1'b1, 1'b1, 5, nvalid, first);
    check("both_nvalid", nvalid, 0);
    check("both_ctrl", ctrl, 2046);

    // UP for 3 edges then the PFD reset overlap ends the measurement at count 3.
    @(posedge clk); #1;
    UP = 1'b1;
    repeat (3) @(posedge clk);
    #1 DN = 1'b1;
    @(posedge clk); #1;
    UP = 1'b0; DN = 1'b0;
    watch_valid(nvalid, first);
    check("overlap_nvalid", nvalid, 1);
    check("overlap_latency", first, 2);
    check("overlap_ctrl", ctrl, 2047);

    do_reset();
    run_pulse(1'b1, 1'b0, 300, nvalid, first);
    check("up300_ctrl", ctrl, 2118);
    check("up300_sat", sat, 0);
    check("up300_nvalid", nvalid, 1);

    for (int k = 0; k < 249; k++) run_pulse(1'b0, 1'b1, 255, nvalid, first);
    check("dn249_ctrl", ctrl, 7);
    check("dn249_sat", sat, 0);
    run_pulse(1'b0, 1'b1, 255, nvalid, first);
    check("dn250_ctrl", ctrl, 0);
    check("dn250_sat", sat, 1);

    @(posedge clk); #1;
    DN = 1'b1;
    repeat (10) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_ctrl", ctrl, 2048);
    check("rst_mid_sat", sat, 0);
    check("rst_mid_valid", ctrl_valid, 0);
    reset = 1'b1;
    DN    = 1'b0;
    watch_valid(nvalid, first);
    check("rst_mid_nvalid", nvalid, 0);
    check("rst_mid_hold", ctrl, 2048);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
